// File: rtl/sipo_ones_rx.sv
// Serial-in/parallel-out byte receiver that also reports the popcount of each completed byte.
// Optional even-parity bit after the data byte is enabled by defining PARITY_CHECK_EN.
module sipo_ones_rx #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       sin,
  input  logic       sin_valid,
  output logic [7:0] data,
  output logic [3:0] ones,
  output logic       data_valid,
  output logic       busy,
  output logic       parity_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned OW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PARITY_CHECK_EN
    ,PAR  = 2'd2
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   data_q, data_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic            dv_q, dv_d;
  logic            busy_q, busy_d;

  logic            accept_c;
  logic            last_bit_c;
  logic [DW-1:0]   sreg_shift_c;
  logic [OW-1:0]   acc_inc_c;

  assign accept_c     = en & sin_valid & ~clr;
  assign last_bit_c   = (state_q == SHIFT) && (cnt_q == CW'(DW - 1));
  assign sreg_shift_c = (MSB_FIRST != 0) ? {sreg_q[DW-2:0], sin} : {sin, sreg_q[DW-1:1]};
  assign acc_inc_c    = acc_q + OW'(sin);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      ones_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      ones_q  <= ones_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; clr wins over any accepted bit
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (accept_c) begin
      case (state_q)
        IDLE:  state_d = SHIFT;
        SHIFT: begin
          if (last_bit_c) begin
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PAR:   state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    data_d = data_q;
    ones_d = ones_q;
    dv_d   = 1'b0;
    busy_d = (state_d != IDLE);
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
      acc_d  = '0;
`ifdef PARITY_CHECK_EN
    end else if (accept_c && state_q == PAR) begin
      // Parity bit: publish the held byte, never count this bit
      data_d = sreg_q;
      ones_d = acc_q;
      dv_d   = 1'b1;
      sreg_d = '0;
      cnt_d  = '0;
      acc_d  = '0;
    end else if (accept_c && last_bit_c) begin
      sreg_d = sreg_shift_c;
      acc_d  = acc_inc_c;
      cnt_d  = '0;
`else
    end else if (accept_c && last_bit_c) begin
      data_d = sreg_shift_c;
      ones_d = acc_inc_c;
      dv_d   = 1'b1;
      sreg_d = '0;
      cnt_d  = '0;
      acc_d  = '0;
`endif
    end else if (accept_c) begin
      sreg_d = sreg_shift_c;
      cnt_d  = cnt_q + CW'(1);
      acc_d  = acc_inc_c;
    end
  end

`ifdef PARITY_CHECK_EN
  logic perr_q, perr_d;

  // Even parity over data plus parity bit, latched only at completion
  always_comb begin
    perr_d = perr_q;
    if (!clr && accept_c && state_q == PAR) begin
      perr_d = (^sreg_q) ^ sin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data       = data_q;
  assign ones       = ones_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_ones_rx.sv
// Scoreboard bench for sipo_ones_rx: MSB-first and LSB-first instances share one serial stream.
module tb_sipo_ones_rx;

`ifdef PARITY_CHECK_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clr = 1'b0, sin = 1'b0, sin_valid = 1'b0;
  logic [7:0] data_m, data_l;
  logic [3:0] ones_m, ones_l;
  logic dv_m, dv_l, busy_m, busy_l, perr_m, perr_l;

  sipo_ones_rx #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .data(data_m), .ones(ones_m), .data_valid(dv_m), .busy(busy_m), .parity_err(perr_m)
  );

  sipo_ones_rx #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .data(data_l), .ones(ones_l), .data_valid(dv_l), .busy(busy_l), .parity_err(perr_l)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] o;
    logic       p;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   pulse_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: every pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && (dv_m || dv_l)) begin
      exp_t e;
      pulse_cyc.push_back(cyc);
      n_checks++;
      if (dv_m !== dv_l || sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: dv_m=%b dv_l=%b pending=%0d required pending>0 and equal pulses",
                 dv_m, dv_l, sb.size());
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (data_m !== e.d) begin
          n_fail++; $display("FAIL data_msb: got %h required %h", data_m, e.d);
        end
        n_checks++;
        if (data_l !== rev8(e.d)) begin
          n_fail++; $display("FAIL data_lsb: got %h required %h", data_l, rev8(e.d));
        end
        n_checks++;
        if (ones_m !== e.o || ones_l !== e.o) begin
          n_fail++; $display("FAIL ones: got %0d/%0d required %0d", ones_m, ones_l, e.o);
        end
        n_checks++;
        if (perr_m !== e.p || perr_l !== e.p) begin
          n_fail++; $display("FAIL parity_err: got %b/%b required %b", perr_m, perr_l, e.p);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    en = 1'b1; clr = 1'b0; sin_valid = 1'b1; sin = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One gap cycle: either no valid bit, or a valid junk bit with en low
  task automatic stall_cycle();
    if ($urandom_range(0, 1) == 0) begin
      en = 1'b1; sin_valid = 1'b0;
    end else begin
      en = 1'b0; sin_valid = 1'b1; sin = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [7:0] b, input logic p);
    exp_t e;
    e.d = b;
    e.o = 4'($countones(b));
`ifdef PARITY_CHECK_EN
    e.p = (^b) ^ p;
`else
    e.p = 1'b0;
`endif
    last_exp = e;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input bit stall);
    for (int i = 7; i >= 0; i--) begin
      if (stall && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) stall_cycle();
`ifndef PARITY_CHECK_EN
      if (i == 0) push_exp(b, p);
`endif
      drive_bit(b[i]);
    end
`ifdef PARITY_CHECK_EN
    if (stall) repeat ($urandom_range(1, 3)) stall_cycle();
    push_exp(b, p);
    drive_bit(p);
`endif
    sin_valid = 1'b0; en = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d frames pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({data_m, ones_m, dv_m, busy_m, perr_m} !== 15'd0) begin
      n_fail++;
      $display("FAIL %s_msb: data=%h ones=%0d dv=%b busy=%b perr=%b required all 0",
               name, data_m, ones_m, dv_m, busy_m, perr_m);
    end
    n_checks++;
    if ({data_l, ones_l, dv_l, busy_l, perr_l} !== 15'd0) begin
      n_fail++;
      $display("FAIL %s_lsb: data=%h ones=%0d dv=%b busy=%b perr=%b required all 0",
               name, data_l, ones_l, dv_l, busy_l, perr_l);
    end
  endtask

  task automatic test_reset();
    #3;
    check_all_zero("reset_initial");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    send_frame(8'hC3, 1'b0, 1'b0);
    idle(1);
    wait_drain("reset_pre");
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    sin_valid = 1'b0;
    rst = 1'b1;
    #2;
    check_all_zero("reset_midframe");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    send_frame(8'h96, 1'b1, 1'b0);
    idle(1);
    wait_drain("reset_post");
  endtask

  task automatic test_msb_byte();
    logic [7:0] b = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
`ifndef PARITY_CHECK_EN
      if (i == 0) push_exp(b, 1'b0);
`endif
      drive_bit(b[i]);
      if (i == 7) begin
        n_checks++;
        if (busy_m !== 1'b1) begin
          n_fail++; $display("FAIL busy_rise: got %b required 1", busy_m);
        end
      end
    end
`ifdef PARITY_CHECK_EN
    push_exp(b, 1'b0);
    drive_bit(1'b0);
`endif
    sin_valid = 1'b0;
    n_checks++;
    if (dv_m !== 1'b1 || data_m !== 8'hB2 || ones_m !== 4'd4) begin
      n_fail++;
      $display("FAIL msb_byte: dv=%b data=%h ones=%0d required dv=1 data=b2 ones=4", dv_m, data_m, ones_m);
    end
    n_checks++;
    if (busy_m !== 1'b0) begin
      n_fail++; $display("FAIL busy_fall: got %b required 0", busy_m);
    end
    idle(1);
    n_checks++;
    if (dv_m !== 1'b0 || data_m !== 8'hB2) begin
      n_fail++; $display("FAIL msb_pulse_width: dv=%b data=%h required dv=0 data=b2", dv_m, data_m);
    end
    wait_drain("msb_byte");
  endtask

  task automatic test_lsb_byte();
    send_frame(8'hB2, 1'b0, 1'b0);
    idle(1);
    wait_drain("lsb_byte");
    n_checks++;
    if (data_l !== 8'h4D || ones_l !== 4'd4) begin
      n_fail++; $display("FAIL lsb_byte: data=%h ones=%0d required data=4d ones=4", data_l, ones_l);
    end
  endtask

  task automatic test_back_to_back();
    pulse_cyc.delete();
    send_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    idle(2);
    wait_drain("b2b");
    n_checks++;
    if (pulse_cyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d required 2", pulse_cyc.size());
    end else begin
      n_checks++;
      if (pulse_cyc[1] - pulse_cyc[0] != FRAME) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d required %0d", pulse_cyc[1] - pulse_cyc[0], FRAME);
      end
    end
    n_checks++;
    if (ones_m !== 4'd0) begin
      n_fail++; $display("FAIL b2b_ones: got %0d required 0", ones_m);
    end
    pulse_cyc.delete();
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    repeat (3) stall_cycle();
    idle(2);
    wait_drain("b2b_stall");
    n_checks++;
    if (pulse_cyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_stall_pulses: got %0d required 2", pulse_cyc.size());
    end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    idle(2);
    wait_drain("random_frames");
  endtask

  task automatic test_abort();
    logic [7:0] b = 8'hF0;
    for (int i = 7; i >= 3; i--) drive_bit(b[i]);
    clr = 1'b1; sin_valid = 1'b1; sin = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; sin_valid = 1'b0;
    n_checks++;
    if (busy_m !== 1'b0 || busy_l !== 1'b0 || dv_m !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: busy=%b/%b dv=%b required 0/0/0", busy_m, busy_l, dv_m);
    end
    n_checks++;
    if (data_m !== last_exp.d || ones_m !== last_exp.o) begin
      n_fail++;
      $display("FAIL abort_hold: data=%h ones=%0d required data=%h ones=%0d",
               data_m, ones_m, last_exp.d, last_exp.o);
    end
    pulse_cyc.delete();
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(2);
    wait_drain("abort_next");
    n_checks++;
    if (pulse_cyc.size() != 1 || data_m !== 8'h5A) begin
      n_fail++; $display("FAIL abort_next: pulses=%0d data=%h required 1 pulse data=5a", pulse_cyc.size(), data_m);
    end
  endtask

  task automatic test_parity();
`ifdef PARITY_CHECK_EN
    send_frame(8'hB2, 1'b0, 1'b0);
    idle(1);
    wait_drain("parity_good");
    n_checks++;
    if (perr_m !== 1'b0 || ones_m !== 4'd4) begin
      n_fail++; $display("FAIL parity_good: perr=%b ones=%0d required 0 and 4", perr_m, ones_m);
    end
    send_frame(8'hB2, 1'b1, 1'b0);
    idle(1);
    wait_drain("parity_bad");
    n_checks++;
    if (perr_m !== 1'b1 || ones_m !== 4'd4) begin
      n_fail++; $display("FAIL parity_bad: perr=%b ones=%0d required 1 and 4", perr_m, ones_m);
    end
    // clr while waiting for the parity bit discards the frame
    pulse_cyc.delete();
    for (int i = 7; i >= 0; i--) drive_bit(1'b1);
    clr = 1'b1; sin_valid = 1'b1; sin = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; sin_valid = 1'b0;
    idle(2);
    n_checks++;
    if (pulse_cyc.size() != 0 || busy_m !== 1'b0 || perr_m !== 1'b1) begin
      n_fail++; $display("FAIL parity_clr: pulses=%0d busy=%b perr=%b required 0/0/1", pulse_cyc.size(), busy_m, perr_m);
    end
`else
    send_frame(8'hB3, 1'b1, 1'b0);
    idle(1);
    wait_drain("parity_off");
    n_checks++;
    if (perr_m !== 1'b0 || perr_l !== 1'b0) begin
      n_fail++; $display("FAIL parity_off: perr=%b/%b required 0", perr_m, perr_l);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_msb_byte();
    test_lsb_byte();
    test_back_to_back();
    test_abort();
    test_parity();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_ones_rx.md
# sipo_ones_rx

Serial-in, parallel-out receiver that assembles bytes from a serial bit stream and reports the number of ones in each completed byte. It is the receiving end of the parallel-load / ones-count datapath. A serializer drives `sin`/`sin_valid`, and this block rebuilds the byte plus its popcount. The popcount feeds the seven-segment display path unchanged.

## Interface
Parameters:
- `MSB_FIRST`, default 1: 1 = first received bit lands in `data[7]`; 0 = first received bit lands in `data[0]`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: receive enable. When low, no bits are accepted and all state holds.
- `clr` in 1: synchronous abort of the partial frame.
- `sin` in 1: serial data bit.
- `sin_valid` in 1: `sin` is accepted on a rising edge when `en`=1 and `clr`=0.
- `data` out 8: last completed byte.
- `ones` out 4: popcount of `data`, range 0..8.
- `data_valid` out 1: one-cycle pulse when a frame completes.
- `busy` out 1: high while a partial frame is held (state ≠ IDLE).
- `parity_err` out 1: parity result of the last frame. Constant 0 without the macro.

## Operation
- **FSM states:**
  - IDLE: 0 bits held.
  - SHIFT: 1..7 bits held.
  - PAR: 8 data bits held, waiting for the parity bit. PAR exists only with `PARITY_CHECK_EN`.
- **Transitions:**
  - IDLE→SHIFT on the first accepted bit.
  - SHIFT stays in SHIFT while the bit counter is below 7.
  - When the 8th bit is accepted: SHIFT→IDLE with the frame completed, or SHIFT→PAR with the macro.
  - PAR→IDLE when the parity bit is accepted, completing the frame.
- **Shift register update:**
  - `MSB_FIRST`=1: `sreg <= {sreg[6:0], sin}`.
  - `MSB_FIRST`=0: `sreg <= {sin, sreg[7:1]}`.
- **Ones accumulation:** a 4-bit accumulator adds `sin` on every accepted data bit. The parity bit is never counted. The accumulator and bit counter clear at frame completion.
- **On frame completion:**
  - `data` ← final sreg value.
  - `ones` ← final accumulator value, with the last bit included.
  - `data_valid` ← 1.
  - `data` and `ones` then hold until the next frame completes.
- **`clr`:**
  - Returns the block to IDLE and clears sreg, the counter and the accumulator.
  - `data`, `ones` and `parity_err` are unchanged.
  - `clr` has priority over `sin_valid` in the same cycle.
- **`en`=0:**
  - Accepted bits are ignored and the partial frame is retained.
  - `data_valid` is 0.
  - `clr` still acts.
- **Reset:** every output is 0, the FSM is in IDLE, and all internal registers are 0. A reset mid-frame discards the frame.

## Timing
- The last bit is sampled at edge N. `data`, `ones`, `data_valid` (and `parity_err`) change at edge N, and `data_valid` is high for exactly one cycle, N to N+1.
- Back-to-back frames: the first bit of the next frame may be accepted at edge N+1 (while `data_valid` is high). There are no gap cycles.
- Minimum frame period is 8 accepted bits, or 9 with parity.
- `sin_valid` gaps of any length are allowed mid-frame. The partial frame holds through them.
- `busy` is registered. It rises at the edge of the first accepted bit and falls at the completion edge or the `clr` edge.

## Configuration
- **`PARITY_CHECK_EN` defined:**
  - A 9th accepted bit is the even-parity bit.
  - The frame completes on the 9th bit.
  - `parity_err` ← (XOR of the 8 data bits) XOR (parity bit). It updates with `data_valid` and holds until the next completion.
  - `clr` in PAR discards the frame.
- **`PARITY_CHECK_EN` undefined:**
  - The frame completes on the 8th bit.
  - The PAR state is absent.
  - `parity_err` is tied to 0.

## Test plan
- **Reset:** assert `rst` mid-frame after 3 bits → all outputs 0, `busy`=0. A new full frame then decodes correctly.
- **MSB-first byte:** `MSB_FIRST`=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles → `data`=0xB2, `ones`=4, `data_valid` high exactly one cycle after the 8th edge.
- **LSB-first byte:** `MSB_FIRST`=0, same bit sequence → `data`=0x4D, `ones`=4.
- **Back-to-back frames with stalls:** frame of 0xFF then 0x00 back-to-back → `ones`=8 then 0, two `data_valid` pulses 8 cycles apart. Repeat with `sin_valid` and `en` gaps inserted → same values, no extra pulses.
- **Abort:** `clr` after 5 bits with `sin_valid` high → the bit is not accepted, `busy`=0, the old `data`/`ones` are retained, and the next 8 bits form a clean frame.
- **Parity (`PARITY_CHECK_EN`):**
  - 0xB2 followed by parity bit 0 → `parity_err`=0.
  - 0xB2 followed by parity bit 1 → `parity_err`=1, `ones`=4 in both cases.
